// File: rtl/hazard_detection_unit.sv
// ID-stage load-use / branch hazard detector with a multi-cycle stall FSM
// and a saturating stall-cycle counter for performance debug.
module hazard_detection_unit #(
    parameter int REG_W          = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             ctrl_sel,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] REM_INIT    = 4'(LOAD_USE_STALL - 1);
    localparam bit         MULTI_STALL = (LOAD_USE_STALL > 1);

    state_t     state;
    logic [3:0] rem;
    logic       hz;

    // $0 is hardwired to zero, so a load targeting it can never feed a consumer.
    assign hz = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        ctrl_sel     = 1'b1;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        stall_active = 1'b0;
        if (rst) begin
            ctrl_sel    = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (state == STALL || hz) begin
            // Stall wins over a taken branch; the branch is re-seen once ID is released.
            ctrl_sel     = 1'b0;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            stall_active = 1'b1;
        end else begin
            if_id_flush = id_branch_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            rem          <= 4'd0;
            stall_cycles <= '0;
        end else begin
            if (stall_active && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            case (state)
                RUN: begin
                    if (hz && MULTI_STALL) begin
                        state <= STALL;
                        rem   <= REM_INIT;
                    end
                end
                STALL: begin
                    rem <= rem - 4'd1;
                    if (rem == 4'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
